// File: rtl/alsu_sequencer.sv
// Two-port request arbiter and pass sequencer that drives a shared combinational ALSU.
// Build option: define ALSU_SEQUENCER_REPEAT_EN to honour req_cnt (cnt+1 passes); otherwise single pass.
module alsu_sequencer #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_op,
    input  logic [1:0]  req_cin,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [5:0]  req_cnt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [7:0]  resp_f,
    output logic        resp_cout,
    output logic        resp_ovf,
    output logic [7:0]  alsu_a,
    output logic [7:0]  alsu_b,
    output logic        alsu_cin,
    output logic [3:0]  alsu_sel,
    input  logic [7:0]  alsu_f,
    input  logic        alsu_cout,
    input  logic        alsu_ovf,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers in a cycle where req_valid[i] && req_ready[i];
    // a response transfers in a cycle where resp_valid && resp_ready. Neither side may
    // retract resp_* while resp_valid is high and resp_ready is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        win_id;
    logic        cur_id;
    logic        cin_q;
    logic [3:0]  op_q;
    logic [7:0]  b_q;
    logic [7:0]  acc;
    logic        final_pass;

`ifdef ALSU_SEQUENCER_REPEAT_EN
    logic [2:0]  pass_left;
    assign final_pass = (pass_left == 3'd0);
`else
    logic        unused_cnt;
    assign unused_cnt = ^req_cnt;
    assign final_pass = 1'b1;
`endif

    assign dbg_state = state;

    always_comb begin
        win_id = req_valid[1];
        if (req_valid == 2'b11) begin
            win_id = (RR_EN != 0) ? ~last_grant : 1'b0;
        end
    end

    // Grant is combinational so a request dropped before this cycle is never latched.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        alsu_a   = 8'h00;
        alsu_b   = 8'h00;
        alsu_sel = 4'h0;
        alsu_cin = 1'b0;
        if (state == EXEC) begin
            alsu_a   = acc;
            alsu_b   = b_q;
            alsu_sel = op_q;
            alsu_cin = cin_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            op_q       <= 4'h0;
            cin_q      <= 1'b0;
            b_q        <= 8'h00;
            acc        <= 8'h00;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_f     <= 8'h00;
            resp_cout  <= 1'b0;
            resp_ovf   <= 1'b0;
`ifdef ALSU_SEQUENCER_REPEAT_EN
            pass_left  <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        last_grant <= win_id;
                        cur_id     <= win_id;
                        op_q       <= win_id ? req_op[7:4]  : req_op[3:0];
                        cin_q      <= win_id ? req_cin[1]   : req_cin[0];
                        acc        <= win_id ? req_a[15:8]  : req_a[7:0];
                        b_q        <= win_id ? req_b[15:8]  : req_b[7:0];
`ifdef ALSU_SEQUENCER_REPEAT_EN
                        pass_left  <= win_id ? req_cnt[5:3] : req_cnt[2:0];
`endif
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    acc <= alsu_f;
                    if (final_pass) begin
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_f     <= alsu_f;
                        resp_cout  <= alsu_cout;
                        resp_ovf   <= alsu_ovf;
                        state      <= DONE;
                    end
`ifdef ALSU_SEQUENCER_REPEAT_EN
                    else begin
                        pass_left <= pass_left - 3'd1;
                    end
`endif
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_sequencer.sv
// Randomized bench for alsu_sequencer: behavioural ALSU, transaction-level reference model and scoreboard.
// Follows the DUT build: define ALSU_SEQUENCER_REPEAT_EN for both to exercise multi-pass operation.
module tb_alsu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = 8'h00;
    logic [1:0]  req_cin = 2'b00;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic [5:0]  req_cnt = 6'h00;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_id;
    logic [7:0]  resp_f;
    logic        resp_cout;
    logic        resp_ovf;
    logic [7:0]  alsu_a, alsu_b, alsu_f;
    logic        alsu_cin, alsu_cout, alsu_ovf;
    logic [3:0]  alsu_sel;
    logic [1:0]  dbg_state;

    logic [1:0]  fp_req_ready;
    logic        fp_resp_valid, fp_resp_id, fp_resp_cout, fp_resp_ovf;
    logic        fp_resp_ready = 1'b1;
    logic [7:0]  fp_resp_f, fp_alsu_a, fp_alsu_b, fp_alsu_f;
    logic        fp_alsu_cin, fp_alsu_cout, fp_alsu_ovf;
    logic [3:0]  fp_alsu_sel;
    logic [1:0]  fp_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int fp_seen = 0;

    logic [10:0] exp_q[$];
    bit          pend = 1'b0;
    bit          last_grant = 1'b1;
    int          exec_lo, exec_hi;
    logic [7:0]  pass_a [0:8];
    logic [3:0]  p_op;
    logic [7:0]  p_b;
    logic        p_cin;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs and behavioural ALSUs ----------------
    alsu_sequencer #(.RR_EN(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_cin(req_cin), .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_f(resp_f),
        .resp_cout(resp_cout), .resp_ovf(resp_ovf),
        .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_cin(alsu_cin), .alsu_sel(alsu_sel),
        .alsu_f(alsu_f), .alsu_cout(alsu_cout), .alsu_ovf(alsu_ovf), .dbg_state(dbg_state)
    );

    alsu_sequencer #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req_op(req_op), .req_cin(req_cin), .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
        .resp_valid(fp_resp_valid), .resp_ready(fp_resp_ready), .resp_id(fp_resp_id), .resp_f(fp_resp_f),
        .resp_cout(fp_resp_cout), .resp_ovf(fp_resp_ovf),
        .alsu_a(fp_alsu_a), .alsu_b(fp_alsu_b), .alsu_cin(fp_alsu_cin), .alsu_sel(fp_alsu_sel),
        .alsu_f(fp_alsu_f), .alsu_cout(fp_alsu_cout), .alsu_ovf(fp_alsu_ovf), .dbg_state(fp_dbg_state)
    );

    function automatic logic [9:0] alsu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic [7:0] f;
        logic co, ov;
        f = a; co = 1'b0; ov = 1'b0;
        case (op)
            4'b0000: begin
                s  = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                f  = s[7:0];
                co = s[8];
                ov = (a[7] == b[7]) && (f[7] != a[7]);
            end
            4'b0100: f = a & b;
            4'b0101: f = a | b;
            4'b0110: f = a ^ b;
            4'b1100: begin
                f  = {a[6:0], 1'b0};
                co = a[7];
                ov = a[7] ^ a[6];
            end
            default: f = a;
        endcase
        return {co, ov, f};
    endfunction

    function automatic int eff_cnt(input logic [2:0] cnt);
`ifdef ALSU_SEQUENCER_REPEAT_EN
        return int'(cnt);
`else
        return 0;
`endif
    endfunction

    always_comb {alsu_cout, alsu_ovf, alsu_f} = alsu_model(alsu_sel, alsu_a, alsu_b, alsu_cin);
    always_comb {fp_alsu_cout, fp_alsu_ovf, fp_alsu_f} = alsu_model(fp_alsu_sel, fp_alsu_a, fp_alsu_b, fp_alsu_cin);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    always @(negedge clk) begin : monitor
        bit         w;
        int         n;
        logic [7:0] a0;
        logic [9:0] r;
        logic [10:0] e;
        if (rst) begin
            exp_q.delete();
            pend = 1'b0;
            last_grant = 1'b1;
        end else begin
            if (pend && cyc >= exec_lo && cyc <= exec_hi)
                check("alsu_drive", {alsu_sel, alsu_cin, alsu_a, alsu_b},
                      {p_op, p_cin, pass_a[cyc - exec_lo], p_b});
            else
                check("alsu_idle", {alsu_sel, alsu_cin, alsu_a, alsu_b}, 32'h0);
            check("resp_valid", resp_valid, pend && (cyc > exec_hi));
            if (req_valid == 2'b11 && fp_req_ready != 2'b00) begin
                check("fp_grant", fp_req_ready, 2'b01);
                fp_seen++;
            end
            if (pend || req_valid == 2'b00) begin
                check("req_ready_idle", req_ready, 2'b00);
            end else begin
                w = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
                check("grant", req_ready, w ? 2'b10 : 2'b01);
                last_grant = w;
                a0    = w ? req_a[15:8] : req_a[7:0];
                p_b   = w ? req_b[15:8] : req_b[7:0];
                p_op  = w ? req_op[7:4] : req_op[3:0];
                p_cin = w ? req_cin[1]  : req_cin[0];
                n     = eff_cnt(w ? req_cnt[5:3] : req_cnt[2:0]);
                pass_a[0] = a0;
                r = '0;
                for (int k = 0; k <= n; k++) begin
                    r = alsu_model(p_op, pass_a[k], p_b, p_cin);
                    pass_a[k + 1] = r[7:0];
                end
                exp_q.push_back({w, r});
                exec_lo = cyc + 1;
                exec_hi = cyc + 1 + n;
                pend = 1'b1;
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", {resp_id, resp_cout, resp_ovf, resp_f}, e);
                end
                pend = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_txn(input int port, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [2:0] cnt, input int hold,
                           output logic [10:0] got, output int lat);
        int n;
        int acc_cyc;
        logic [9:0] r;
        logic [7:0] x;
        x = a;
        r = '0;
        for (int k = 0; k <= eff_cnt(cnt); k++) begin
            r = alsu_model(op, x, b, cin);
            x = r[7:0];
        end
        got = '0;
        lat = 0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_valid[port] = 1'b1;
        req_op[4*port +: 4]  = op;
        req_a[8*port +: 8]   = a;
        req_b[8*port +: 8]   = b;
        req_cin[port]        = cin;
        req_cnt[3*port +: 3] = cnt;
        resp_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[port] && n < 20);
        check("accept", req_ready[port], 1'b1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 2'b00;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        lat = cyc - acc_cyc;
        got = {resp_id, resp_cout, resp_ovf, resp_f};
        check("latency", lat, eff_cnt(cnt) + 2);
        check("txn_resp", got, {port[0], r});
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            check("hold_resp", {resp_valid, resp_id, resp_cout, resp_ovf, resp_f}, {1'b1, port[0], r});
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        for (int i = 0; i < 40 && pend; i++) @(negedge clk);
        check("drain", pend, 1'b0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [10:0] got;
        int          lat;
        int          grants;
        int          n;
        logic [3:0]  seq;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp", {req_ready, resp_valid, resp_id, resp_f, resp_cout, resp_ovf}, 32'h0);
        check("rst_alsu", {alsu_a, alsu_b, alsu_cin, alsu_sel}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Four-pass shift: 01 -> 02 -> 04 -> 08 -> 10
        run_txn(0, 4'b1100, 8'h01, 8'h00, 1'b0, 3'd3, 0, got, lat);
`ifdef ALSU_SEQUENCER_REPEAT_EN
        check("shl_multi", got, 11'h010);
        check("shl_multi_lat", lat, 5);
`else
        check("shl_single", got, 11'h002);
        check("shl_single_lat", lat, 2);
`endif
        run_txn(0, 4'b1100, 8'h81, 8'h00, 1'b0, 3'd0, 0, got, lat);
        check("shl_cout", got, 11'h302);
        run_txn(1, 4'b0100, 8'hF0, 8'h3C, 1'b0, 3'd0, 4, got, lat);
        check("and_hold", got, 11'h430);
        run_txn(0, 4'b0000, 8'h11, 8'h22, 1'b1, 3'd7, 1, got, lat);
`ifdef ALSU_SEQUENCER_REPEAT_EN
        check("cnt7_lat", lat, 9);
`else
        check("cnt7_lat", lat, 2);
`endif

        // Both ports requesting continuously: last grant was port 0, so 1,0,1,0
        resp_ready = 1'b1;
        grants = 0;
        seq = 4'h0;
        for (int c = 0; c < 300 && grants < 6; c++) begin
            @(posedge clk); #1;
            req_valid = 2'b11;
            req_op    = 8'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_cin   = 2'($urandom);
            req_cnt   = 6'($urandom);
            @(negedge clk);
            if (req_ready != 2'b00) begin
                if (grants < 4) seq[3 - grants] = req_ready[1];
                grants++;
            end
        end
        check("rr_grants", grants, 6);
        check("rr_seq", seq, 4'b1010);
        check("fp_seen", fp_seen > 0, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();

        // Reset in the second EXEC cycle aborts silently and restores the pointer
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_op[3:0] = 4'b0000; req_a[7:0] = 8'h5A; req_b[7:0] = 8'h13; req_cin[0] = 1'b0; req_cnt[2:0] = 3'd5;
        resp_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 20);
        check("rst_op_accept", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_resp", {req_ready, resp_valid, resp_id, resp_f, resp_cout, resp_ovf}, 32'h0);
        check("post_rst_alsu", {alsu_a, alsu_b, alsu_cin, alsu_sel}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_replay", resp_valid, 1'b0);
        end
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_cnt = 6'h00;
        @(negedge clk);
        check("post_rst_port0", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();

        // Randomized single-port transactions
        for (int t = 0; t < 25; t++) begin
            run_txn(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                    1'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), got, lat);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
